uart_echo_sched: RTL and testbench
==================================

Name: uart_echo_sched

Overview:
- Ring-buffer scheduler that places the shared byte RAM between the UART receiver (writer) and the UART transmitter (reader).
- Owns the write and read pointers, full/empty detection and the overflow policy.
- Sequences each RAM read through the one-cycle RAM latency into a single tx_dv pulse, then waits for the transmitter to finish.
- Sits between uart_rx, ram and uart_tx2 at the top level, replacing ad-hoc pointer logic there.

Parameters:
- ADDR_W, 9, RAM address width; buffer depth = 2**ADDR_W bytes.
- RAM_LAT, 1, cycles from read address to valid ram_dout (legal values 1 or 2).

Ports:
- ICE_CLK  in  1  system clock.
- RST_N  in  1  asynchronous active-low reset.
- rx_dv  in  1  one-cycle strobe: rx_byte valid.
- rx_byte  in  8  received byte.
- tx_done  in  1  high = transmitter idle.
- ram_dout  in  8  RAM read data.
- ram_write_addr  out  ADDR_W  RAM write address.
- ram_din  out  8  RAM write data (registered rx_byte).
- ram_write_en  out  1  RAM write strobe.
- ram_read_addr  out  ADDR_W  RAM read address.
- tx_dv  out  1  one-cycle send strobe.
- tx_byte  out  8  byte to send, held stable from tx_dv until the next tx_dv.
- full  out  1  buffer holds 2**ADDR_W bytes.
- empty  out  1  buffer holds 0 bytes.
- overflow  out  1  sticky: a byte was dropped.

Behaviour:
- Reset (async assert, sync release): pointers 0, all strobes 0, tx_byte 0, empty=1, full=0, overflow=0, FSM IDLE. Assertion mid-frame aborts the sequence; buffer contents are discarded.
- Pointers wr_ptr and rd_ptr are ADDR_W+1 bits. Low ADDR_W bits drive the RAM addresses. Modulo-2**(ADDR_W+1) wrap.
- empty = (wr_ptr == rd_ptr).
- full = (MSBs differ and low bits equal).
- Write path, on rx_dv:
  - Not full: next cycle ram_write_en=1, ram_din=rx_byte, ram_write_addr=wr_ptr[ADDR_W-1:0]; wr_ptr increments in that same cycle.
  - Full: byte dropped, no write, overflow set until reset.
- Read FSM:
  - IDLE: if !empty and tx_done, drive ram_read_addr=rd_ptr and go to FETCH.
  - FETCH: wait RAM_LAT cycles, then latch tx_byte=ram_dout, pulse tx_dv for one cycle, increment rd_ptr, go to WAIT_BUSY.
  - WAIT_BUSY: wait for tx_done=0, then go to WAIT_DONE. No timeout.
  - WAIT_DONE: wait for tx_done=1, then go to IDLE.
  - Minimum spacing between tx_dv pulses: RAM_LAT+3 cycles.
- Simultaneous rx_dv and read-pointer increment: both pointers update; full/empty are computed from the updated values the following cycle.
- A write to the same address being read in FETCH cannot occur: that slot is occupied, so writes into it are blocked by full.
- empty/full are registered and reflect the pointers one cycle after each update.

Optional Feature:
- Macro CRLF_EXPAND_EN.
- Defined: after a 0x0D byte completes (WAIT_DONE→IDLE), the FSM enters INSERT_LF, drives tx_byte=0x0A, pulses tx_dv, and follows WAIT_BUSY/WAIT_DONE without advancing rd_ptr. This takes priority over the next buffered byte.
- Undefined: INSERT_LF state and logic are absent; bytes are echoed verbatim.

Decomposition:
- Shared package uart_pkg holds:
  - FSM state enum: IDLE, FETCH, WAIT_BUSY, WAIT_DONE, INSERT_LF.
  - constants CHAR_CR=8'h0D and CHAR_LF=8'h0A.
  - default baud/depth constants already used by uart_rx and uart_tx2.
- One sub-module, ring_ptrs: pointer registers, increment, and full/empty/overflow flags.
- The FSM stays in uart_echo_sched.

Test Plan:
- Reset check: after RST_N release, empty=1, full=0, tx_dv=0, both addresses 0.
- Single byte: rx 0x41 with tx model (tx_done low 10 cycles after tx_dv) -> ram_write_en at addr 0, then tx_dv with tx_byte=0x41 RAM_LAT+1 cycles after IDLE, then empty=1.
- Ordering: rx burst 0x01..0x05 while tx busy -> sent in order 0x01..0x05, rd_ptr=5, no overflow.
- Wrap and full: ADDR_W=3, tx_done held 0, 9 rx bytes -> full=1 after the 8th, 9th dropped, overflow=1. Release tx -> exactly 8 bytes sent in order; pointers wrap past 7 correctly.
- Reset mid-send: assert RST_N in WAIT_BUSY -> tx_dv=0 immediately, empty=1, and no further tx_dv after release.
- With CRLF_EXPAND_EN: rx 0x0D,0x42 -> tx sequence 0x0D,0x0A,0x42. Without the macro -> 0x0D,0x42.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: echo scheduler FSM states, special
// characters, and the default baud/depth constants of the UART blocks.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT_BUSY,
        WAIT_DONE,
        INSERT_LF
    } sched_state_t;

    localparam logic [7:0] CHAR_CR = 8'h0D;
    localparam logic [7:0] CHAR_LF = 8'h0A;

    localparam int CLK_HZ       = 12_000_000;
    localparam int BAUD         = 115_200;
    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int BUF_ADDR_W   = 9;

endpackage

// File: rtl/uart_echo_sched_ring_ptrs.sv
// Ring-buffer pointers with registered full/empty and sticky overflow.
// Ports: clk, rst_n (async low), wr_req, rd_inc in; wr_ok, wr_addr,
// rd_addr, full, empty, overflow out.
module ring_ptrs #(
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_req,
    input  logic              rd_inc,
    output logic              wr_ok,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              full,
    output logic              empty,
    output logic              overflow
);

    logic [ADDR_W:0] wr_ptr;
    logic [ADDR_W:0] rd_ptr;
    logic            full_now;

    // Exact occupancy test on the live pointers so that back-to-back
    // writes can never overrun, even though the flag outputs lag.
    assign full_now = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                      (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
    assign wr_ok    = wr_req && !full_now;
    assign wr_addr  = wr_ptr[ADDR_W-1:0];
    assign rd_addr  = rd_ptr[ADDR_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            if (wr_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (rd_inc)
                rd_ptr <= rd_ptr + 1'b1;
            full     <= full_now;
            empty    <= (wr_ptr == rd_ptr);
            overflow <= overflow | (wr_req & full_now);
        end
    end

endmodule

// File: rtl/uart_echo_sched.sv
// Echo scheduler: buffers received bytes in a shared RAM and feeds them
// one at a time to the transmitter.
// Ports: ICE_CLK, RST_N (async low), rx_dv/rx_byte from the receiver,
// tx_done from the transmitter, ram_dout from the RAM; RAM write/read
// address, ram_din, ram_write_en, tx_dv/tx_byte, full, empty, overflow.
// Build option: CRLF_EXPAND_EN appends 0x0A after every echoed 0x0D.
module uart_echo_sched
    import uart_pkg::*;
#(
    parameter int ADDR_W  = 9,
    parameter int RAM_LAT = 1
) (
    input  logic              ICE_CLK,
    input  logic              RST_N,
    input  logic              rx_dv,
    input  logic [7:0]        rx_byte,
    input  logic              tx_done,
    input  logic [7:0]        ram_dout,
    output logic [ADDR_W-1:0] ram_write_addr,
    output logic [7:0]        ram_din,
    output logic              ram_write_en,
    output logic [ADDR_W-1:0] ram_read_addr,
    output logic              tx_dv,
    output logic [7:0]        tx_byte,
    output logic              full,
    output logic              empty,
    output logic              overflow
);

    localparam logic [1:0] LAT_M1 = 2'(RAM_LAT - 1);

    sched_state_t      state;
    sched_state_t      state_n;
    logic [1:0]        cnt;
    logic              load_byte;
    logic              rd_inc;
    logic              wr_ok;
    logic [ADDR_W-1:0] wr_addr;
`ifdef CRLF_EXPAND_EN
    logic              load_lf;
`endif

    ring_ptrs #(
        .ADDR_W (ADDR_W)
    ) u_ptrs (
        .clk      (ICE_CLK),
        .rst_n    (RST_N),
        .wr_req   (rx_dv),
        .rd_inc   (rd_inc),
        .wr_ok    (wr_ok),
        .wr_addr  (wr_addr),
        .rd_addr  (ram_read_addr),
        .full     (full),
        .empty    (empty),
        .overflow (overflow)
    );

    always_ff @(posedge ICE_CLK or negedge RST_N) begin
        if (!RST_N) begin
            ram_write_en   <= 1'b0;
            ram_write_addr <= '0;
            ram_din        <= 8'h00;
        end else begin
            ram_write_en <= wr_ok;
            if (wr_ok) begin
                ram_write_addr <= wr_addr;
                ram_din        <= rx_byte;
            end
        end
    end

    always_comb begin
        state_n   = state;
        load_byte = 1'b0;
        rd_inc    = 1'b0;
`ifdef CRLF_EXPAND_EN
        load_lf   = 1'b0;
`endif
        unique case (state)
            IDLE: begin
                if (!empty && tx_done)
                    state_n = FETCH;
            end
            FETCH: begin
                // The read address has been stable since IDLE, so the
                // data is valid once RAM_LAT cycles have elapsed.
                if (cnt == LAT_M1) begin
                    load_byte = 1'b1;
                    rd_inc    = 1'b1;
                    state_n   = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                if (!tx_done)
                    state_n = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (tx_done) begin
`ifdef CRLF_EXPAND_EN
                    // tx_byte still holds the byte just sent; LF itself
                    // never triggers another insertion.
                    if (tx_byte == CHAR_CR)
                        state_n = INSERT_LF;
                    else
                        state_n = IDLE;
`else
                    state_n = IDLE;
`endif
                end
            end
`ifdef CRLF_EXPAND_EN
            INSERT_LF: begin
                load_lf = 1'b1;
                state_n = WAIT_BUSY;
            end
`endif
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge ICE_CLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= IDLE;
            cnt     <= 2'd0;
            tx_dv   <= 1'b0;
            tx_byte <= 8'h00;
        end else begin
            state <= state_n;
            if (state == FETCH)
                cnt <= cnt + 2'd1;
            else
                cnt <= 2'd0;
`ifdef CRLF_EXPAND_EN
            tx_dv <= load_byte | load_lf;
            if (load_byte)
                tx_byte <= ram_dout;
            else if (load_lf)
                tx_byte <= CHAR_LF;
`else
            tx_dv <= load_byte;
            if (load_byte)
                tx_byte <= ram_dout;
`endif
        end
    end

endmodule

// File: tb/tb_uart_echo_sched.sv
// Directed self-checking bench for uart_echo_sched (ADDR_W=3, RAM_LAT=1)
// with a synchronous RAM model and a transmitter busy-time model.
module tb_uart_echo_sched;

    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rx_dv = 1'b0;
    logic [7:0]    rx_byte = 8'h00;
    logic          tx_done;
    logic [7:0]    ram_dout;
    logic [AW-1:0] ram_write_addr;
    logic [7:0]    ram_din;
    logic          ram_write_en;
    logic [AW-1:0] ram_read_addr;
    logic          tx_dv;
    logic [7:0]    tx_byte;
    logic          full;
    logic          empty;
    logic          overflow;

    int checks = 0;
    int errors = 0;

    logic       hold = 1'b0;
    int         busy_cnt = 0;
    logic [7:0] mem [8];
    logic [7:0] sent [$];

    uart_echo_sched #(
        .ADDR_W  (AW),
        .RAM_LAT (1)
    ) dut (
        .ICE_CLK        (clk),
        .RST_N          (rst_n),
        .rx_dv          (rx_dv),
        .rx_byte        (rx_byte),
        .tx_done        (tx_done),
        .ram_dout       (ram_dout),
        .ram_write_addr (ram_write_addr),
        .ram_din        (ram_din),
        .ram_write_en   (ram_write_en),
        .ram_read_addr  (ram_read_addr),
        .tx_dv          (tx_dv),
        .tx_byte        (tx_byte),
        .full           (full),
        .empty          (empty),
        .overflow       (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_write_en)
            mem[ram_write_addr] <= ram_din;
        ram_dout <= mem[ram_read_addr];
    end

    always @(posedge clk) begin
        if (tx_dv) begin
            busy_cnt <= 10;
            sent.push_back(tx_byte);
        end else if (busy_cnt > 0) begin
            busy_cnt <= busy_cnt - 1;
        end
    end

    assign tx_done = (busy_cnt == 0) && !hold;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_rx(input logic [7:0] b);
        @(posedge clk);
        #1;
        rx_dv   = 1'b1;
        rx_byte = b;
        @(posedge clk);
        #1;
        rx_dv   = 1'b0;
    endtask

    task automatic wait_sent(input int n, input int bound);
        int k;
        k = 0;
        while (sent.size() < n && k < bound) begin
            @(negedge clk);
            k++;
        end
    endtask

    initial begin
        int n;
        int base;

        // reset
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_tx_dv", tx_dv, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_waddr", ram_write_addr, 0);
        chk("rst_raddr", ram_read_addr, 0);

        // single byte and its latency
        send_rx(8'h41);
        @(negedge clk);
        chk("one_we", ram_write_en, 1);
        chk("one_waddr", ram_write_addr, 0);
        chk("one_din", ram_din, 8'h41);
        n = 0;
        while (!tx_dv && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("one_lat", n, 3);
        chk("one_txb", tx_byte, 8'h41);
        repeat (30) @(negedge clk);
        chk("one_empty", empty, 1);
        chk("one_cnt", sent.size(), 1);

        // ordered burst while transmitter is held busy
        hold = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            send_rx(8'(i));
            repeat (2) @(negedge clk);
        end
        chk("ord_held", sent.size(), 1);
        chk("ord_nempty", empty, 0);
        hold = 1'b0;
        wait_sent(6, 400);
        chk("ord_cnt", sent.size(), 6);
        for (int i = 0; i < 5; i++)
            chk("ord_byte", (sent.size() > 1 + i) ? sent[1 + i] : 8'hxx,
                32'(i + 1));
        repeat (20) @(negedge clk);
        chk("ord_empty", empty, 1);
        chk("ord_ovf", overflow, 0);
        chk("ord_raddr", ram_read_addr, 6);

        // fill to full with wrap, then one dropped byte
        hold = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send_rx(8'h10 + 8'(i));
            repeat (2) @(negedge clk);
        end
        repeat (2) @(negedge clk);
        chk("wrap_full", full, 1);
        chk("wrap_ovf0", overflow, 0);
        send_rx(8'h18);
        repeat (3) @(negedge clk);
        chk("wrap_ovf1", overflow, 1);
        chk("wrap_full2", full, 1);
        chk("wrap_waddr", ram_write_addr, 5);
        hold = 1'b0;
        wait_sent(14, 800);
        chk("wrap_cnt", sent.size(), 14);
        for (int i = 0; i < 8; i++)
            chk("wrap_byte", (sent.size() > 6 + i) ? sent[6 + i] : 8'hxx,
                32'(8'h10 + i));
        repeat (60) @(negedge clk);
        chk("wrap_nomore", sent.size(), 14);
        chk("wrap_empty", empty, 1);
        chk("wrap_nfull", full, 0);
        chk("wrap_ovf_stk", overflow, 1);
        chk("wrap_raddr", ram_read_addr, 6);

        // reset asserted while waiting on the transmitter
        send_rx(8'h55);
        n = 0;
        while (!tx_dv && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("mid_seen", tx_dv, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_txdv", tx_dv, 0);
        chk("mid_empty", empty, 1);
        chk("mid_ovf", overflow, 0);
        chk("mid_raddr", ram_read_addr, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        base = sent.size();
        repeat (60) @(negedge clk);
        chk("mid_silent", sent.size(), base);

        // carriage return handling
        send_rx(8'h0D);
        repeat (2) @(negedge clk);
        send_rx(8'h42);
`ifdef CRLF_EXPAND_EN
        wait_sent(base + 3, 400);
        chk("cr_cnt", sent.size(), base + 3);
        chk("cr_b0", (sent.size() > base) ? sent[base] : 8'hxx, 8'h0D);
        chk("cr_b1", (sent.size() > base + 1) ? sent[base + 1] : 8'hxx,
            8'h0A);
        chk("cr_b2", (sent.size() > base + 2) ? sent[base + 2] : 8'hxx,
            8'h42);
        repeat (60) @(negedge clk);
        chk("cr_nomore", sent.size(), base + 3);
`else
        wait_sent(base + 2, 400);
        chk("cr_cnt", sent.size(), base + 2);
        chk("cr_b0", (sent.size() > base) ? sent[base] : 8'hxx, 8'h0D);
        chk("cr_b1", (sent.size() > base + 1) ? sent[base + 1] : 8'hxx,
            8'h42);
        repeat (60) @(negedge clk);
        chk("cr_nomore", sent.size(), base + 2);
`endif
        chk("cr_empty", empty, 1);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
